// File: rtl/bch_link_pkg.sv
// Shared definitions for the BCH(204,128) voice link.
//   LFSR_POLY          : right-shift Galois toggle mask for x^32+x^22+x^2+x+1
//   LFSR_DEFAULT_SEED  : default noise LFSR seed
//   BCH_T              : correction capability of the BCH code
//   avst_beat_t        : one Avalon-ST beat (data, sop, eop); data sized for
//                        the widest supported symbol
//   lfsr_next()        : one Galois LFSR step
package bch_link_pkg;

  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_2468;
  localparam int          BCH_T             = 10;
  localparam int          BEAT_MAX_W        = 16;

  typedef struct packed {
    logic [BEAT_MAX_W-1:0] data;
    logic                  sop;
    logic                  eop;
  } avst_beat_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR, steps once per cycle with advance high.
//   clk     : clock
//   reset   : asynchronous active-low reset, reloads SEED
//   advance : step enable
//   q       : current state
module lfsr32_galois
  import bch_link_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (advance) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bch_channel_noise.sv
// Noisy channel between the BCH encoder and decoder. One register stage on
// an Avalon-ST byte stream; flips at most one pseudo-random bit per beat
// under a per-packet error budget.
// Optional feature macro: BCH_NOISE_STATS_EN builds the statistics outputs
// (errs_injected, pkt_count, framing_err); without it they are tied to 0.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_sop/in_eop/in_data       : upstream beat
//   out_valid/out_ready/out_sop/out_eop/out_data  : downstream beat
//   inject_en   : global injection enable
//   rate_thresh : per-beat flip probability ~ rate_thresh/65536 (FFFF = always)
//   err_limit   : requested flips per packet, clamped to MAX_ERR
//   errs_injected, pkt_count, framing_err : packet statistics
module bch_channel_noise
  import bch_link_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          MAX_ERR   = BCH_T,
  parameter logic [31:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [DATA_W-1:0] out_data,
  input  logic              inject_en,
  input  logic [15:0]       rate_thresh,
  input  logic [7:0]        err_limit,
  output logic [7:0]        errs_injected,
  output logic [15:0]       pkt_count,
  output logic              framing_err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  function automatic logic [7:0] sat_limit(input logic [7:0] req);
    return (req > 8'(MAX_ERR)) ? 8'(MAX_ERR) : req;
  endfunction

  logic              in_xfer;
  logic [31:0]       lfsr_q;
  logic              in_pkt;
  logic [7:0]        budget_used;
  logic [7:0]        budget_base;
  logic [7:0]        budget_next;
  logic              beat_ok;
  logic              rate_hit;
  logic              flip;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] flip_mask;
  logic              vld_p0;
  logic              sop_p0;
  logic              eop_p0;
  logic [DATA_W-1:0] data_p0;
  logic              unused_lfsr;

  assign in_ready = ~vld_p0 | out_ready;
  assign in_xfer  = in_valid & in_ready;

  // Stepping only on accepted beats keeps the flip pattern a function of
  // beat index alone, independent of downstream stalls.
  lfsr32_galois #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (in_xfer),
    .q       (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[31:16+IDX_W];

  always_comb begin
    // A sop beat starts a fresh budget even if the previous packet never closed.
    budget_base = in_sop ? 8'd0 : budget_used;
    beat_ok     = in_sop | in_pkt;
    rate_hit    = (rate_thresh == 16'hFFFF) | (lfsr_q[15:0] < rate_thresh);
    flip        = inject_en & beat_ok & rate_hit & (budget_base < sat_limit(err_limit));
    budget_next = budget_base + 8'(flip);
    bit_idx     = (DATA_W > 1) ? lfsr_q[16 +: IDX_W] : '0;
    flip_mask   = flip ? (DATA_W'(1) << bit_idx) : '0;
  end

  // Stage p0: output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      sop_p0  <= 1'b0;
      eop_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (in_xfer) begin
      vld_p0  <= 1'b1;
      sop_p0  <= in_sop;
      eop_p0  <= in_eop;
      data_p0 <= in_data ^ flip_mask;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign out_valid = vld_p0;
  assign out_sop   = sop_p0;
  assign out_eop   = eop_p0;
  assign out_data  = data_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_pkt      <= 1'b0;
      budget_used <= 8'd0;
    end else if (in_xfer) begin
      in_pkt      <= beat_ok & ~in_eop;
      budget_used <= budget_next;
    end
  end

`ifdef BCH_NOISE_STATS_EN
  logic [7:0]  errs_q;
  logic [15:0] pkt_q;
  logic        ferr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      errs_q <= 8'd0;
      pkt_q  <= 16'd0;
      ferr_q <= 1'b0;
    end else if (in_xfer) begin
      if (in_sop == in_pkt) begin
        ferr_q <= 1'b1;
      end
      // An eop outside a packet is a framing error, not a completed packet.
      if (in_eop & beat_ok) begin
        errs_q <= budget_next;
        pkt_q  <= pkt_q + 16'd1;
      end
    end
  end

  assign errs_injected = errs_q;
  assign pkt_count     = pkt_q;
  assign framing_err   = ferr_q;
`else
  assign errs_injected = 8'd0;
  assign pkt_count     = 16'd0;
  assign framing_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bch_channel_noise.sv
module tb_bch_channel_noise;
  import bch_link_pkg::*;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam int          MAXE = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid, out_sop, out_eop;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        inject_en = 1'b0;
  logic [15:0] rate_thresh = 16'h0000;
  logic [7:0]  err_limit = 8'd0;
  logic [7:0]  errs_injected;
  logic [15:0] pkt_count;
  logic        framing_err;

  bch_channel_noise #(.DATA_W(8), .MAX_ERR(MAXE), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .inject_en(inject_en), .rate_thresh(rate_thresh), .err_limit(err_limit),
    .errs_injected(errs_injected), .pkt_count(pkt_count), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    avst_beat_t b;
    logic [7:0] src;
  } exp_t;

  exp_t        mq[$];
  logic [7:0]  cap[$];
  logic [7:0]  cap1[$];
  logic [7:0]  xq[$];
  logic [7:0]  pkt_data[26];

  // Behavioural channel model state
  logic [31:0] m_lfsr = SEED;
  bit          m_in_pkt = 0;
  int          m_used = 0;
  int          m_errs = 0;
  int          m_pkts = 0;
  bit          m_ferr = 0;

  int  rdy_mode = 0;
  bit  rnd_rate = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef BCH_NOISE_STATS_EN
    return v;
`else
    return v & 32'h0;
`endif
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Downstream ready pattern
  initial begin
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Observer: samples 1 time unit before each rising edge
  initial begin : observer
    exp_t        e;
    bit          prev_in, prev_hold, active, flip;
    logic        h_sop, h_eop;
    logic [7:0]  h_data, mask;
    int          lim;
    prev_in = 0; prev_hold = 0; h_sop = 0; h_eop = 0; h_data = 0;
    forever begin
      @(negedge clk); #4;
      if (!reset) begin
        prev_in = 0; prev_hold = 0;
      end else begin
        chk("in_ready", in_ready, !out_valid || out_ready);
        chk("errs_injected", errs_injected, st(m_errs));
        chk("pkt_count", pkt_count, st(m_pkts));
        chk("framing_err", framing_err, st(m_ferr));
        if (prev_in) chk("latency", out_valid, 1);
        if (prev_hold) chk("stall_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, h_sop, h_eop, h_data});
        if (out_valid && out_ready) begin
          if (mq.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = mq.pop_front();
            chk("out_data", {8'h00, out_data}, e.b.data);
            chk("out_flags", {out_sop, out_eop}, {e.b.sop, e.b.eop});
            cap.push_back(out_data);
            xq.push_back(out_data ^ e.src);
          end
        end
        prev_hold = out_valid && !out_ready;
        h_sop = out_sop; h_eop = out_eop; h_data = out_data;
        prev_in = in_valid && in_ready;
        if (prev_in) begin
          lim = (err_limit > MAXE) ? MAXE : int'(err_limit);
          active = in_sop || m_in_pkt;
          if (in_sop) begin
            if (m_in_pkt) m_ferr = 1;
            m_used = 0;
          end else if (!m_in_pkt) begin
            m_ferr = 1;
          end
          flip = inject_en && active && (m_used < lim) &&
                 ((rate_thresh == 16'hFFFF) || (m_lfsr[15:0] < rate_thresh));
          mask = flip ? (8'h01 << m_lfsr[18:16]) : 8'h00;
          if (flip) m_used++;
          e.b.data = {8'h00, in_data ^ mask};
          e.b.sop  = in_sop;
          e.b.eop  = in_eop;
          e.src    = in_data;
          mq.push_back(e);
          if (active && in_eop) begin
            m_errs = m_used;
            m_pkts = (m_pkts + 1) & 16'hFFFF;
            m_in_pkt = 0;
          end else if (in_sop) begin
            m_in_pkt = 1;
          end
          m_lfsr = lfsr_step(m_lfsr);
        end
      end
    end
  end

  task automatic do_reset();
    in_valid = 0; in_sop = 0; in_eop = 0;
    reset = 0;
    mq.delete();
    m_lfsr = SEED; m_in_pkt = 0; m_used = 0; m_errs = 0; m_pkts = 0; m_ferr = 0;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_flags", {out_sop, out_eop}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_errs", errs_injected, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_framing_err", framing_err, 0);
    @(negedge clk);
    reset = 1;
  endtask

  // Sends beats [0, min(len,stop_at)) of a len-beat packet, from pkt_data or random
  task automatic send_pkt(input int len, input int stop_at, input bit use_arr, input bit no_sop);
    for (int b = 0; b < len && b < stop_at; b++) begin
      bit rdy;
      int w;
      @(negedge clk);
      in_valid = 1;
      in_sop   = (b == 0) && !no_sop;
      in_eop   = (b == len - 1);
      in_data  = use_arr ? pkt_data[b] : 8'($urandom);
      if (rnd_rate) rate_thresh = 16'($urandom);
      w = 0;
      forever begin
        #4; rdy = in_ready;
        @(posedge clk);
        if (rdy) break;
        w++;
        if (w > 200) begin
          chk("ready_timeout", 1, 0);
          break;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 0; in_sop = 0; in_eop = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (mq.size() != 0 || out_valid); i++) @(negedge clk);
    chk("drain_empty", mq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n1, n0, nz, mis;
    for (int i = 0; i < 26; i++) pkt_data[i] = 8'($urandom);

    // Pin the model's LFSR step to hand-computed values
    chk("model_step_seed", lfsr_step(32'hACE1_2468), 32'h5670_9234);
    chk("model_step_one", lfsr_step(32'h0000_0001), 32'h8020_0003);

    @(negedge clk);
    do_reset();

    // 1: injection disabled
    inject_en = 0; rate_thresh = 16'hFFFF; err_limit = 8'd10; xq.delete();
    send_pkt(26, 26, 0, 0); drain();
    nz = 0; foreach (xq[i]) if (xq[i] != 0) nz++;
    chk("t1_beats", xq.size(), 26);
    chk("t1_flips", nz, 0);
    chk("t1_errs", errs_injected, st(0));
    chk("t1_pkts", pkt_count, st(1));

    // 2: always flip, limit 10
    inject_en = 1; rate_thresh = 16'hFFFF; err_limit = 8'd10; xq.delete();
    send_pkt(26, 26, 0, 0); drain();
    n1 = 0; n0 = 0;
    foreach (xq[i]) begin
      if (i < 10 && $countones(xq[i]) == 1) n1++;
      if (i >= 10 && xq[i] == 0) n0++;
    end
    chk("t2_beats", xq.size(), 26);
    chk("t2_first10_onebit", n1, 10);
    chk("t2_rest_exact", n0, 16);
    chk("t2_errs", errs_injected, st(10));

    // 3: limit above MAX_ERR is clamped
    err_limit = 8'd25; xq.delete();
    send_pkt(26, 26, 0, 0); drain();
    nz = 0; foreach (xq[i]) nz += $countones(xq[i]);
    chk("t3_total_flips", nz, 10);
    chk("t3_errs", errs_injected, st(10));

    // 4: rate 0, three packets
    rate_thresh = 16'h0000; err_limit = 8'd10; xq.delete();
    for (int p = 0; p < 3; p++) send_pkt(26, 26, 0, 0);
    drain();
    nz = 0; foreach (xq[i]) if (xq[i] != 0) nz++;
    chk("t4_flips", nz, 0);
    chk("t4_pkts", pkt_count, st(6));

    // 5: same packet, full rate vs toggling ready
    do_reset();
    inject_en = 1; rate_thresh = 16'hFFFF; err_limit = 8'd4; rdy_mode = 0;
    cap.delete(); xq.delete();
    send_pkt(26, 26, 1, 0); drain();
    cap1 = cap;
    chk("t5_first_flip", xq[0], 8'h02);
    chk("t5_second_flip", xq[1], 8'h01);
    nz = 0; foreach (xq[i]) if (xq[i] != 0) nz++;
    chk("t5_flip_count", nz, 4);
    do_reset();
    rdy_mode = 1; cap.delete();
    send_pkt(26, 26, 1, 0); drain();
    rdy_mode = 0;
    mis = 0; foreach (cap[i]) if (i < cap1.size() && cap[i] != cap1[i]) mis++;
    chk("t5_stall_len", cap.size(), 26);
    chk("t5_stall_same", mis, 0);

    // 6: reset in mid-packet, then a fresh packet repeats the first pattern
    do_reset();
    send_pkt(26, 12, 1, 0);
    do_reset();
    cap.delete();
    send_pkt(26, 26, 1, 0); drain();
    mis = 0; foreach (cap[i]) if (i < cap1.size() && cap[i] != cap1[i]) mis++;
    chk("t6_len", cap.size(), 26);
    chk("t6_same_pattern", mis, 0);
    chk("t6_framing", framing_err, 0);

    // Randomised packets with random backpressure and per-beat rate changes
    rdy_mode = 2;
    for (int p = 0; p < 15; p++) begin
      inject_en = ($urandom_range(0, 3) != 0);
      err_limit = 8'($urandom_range(0, 14));
      case ($urandom_range(0, 2))
        0: rate_thresh = 16'hFFFF;
        1: rate_thresh = 16'h0000;
        default: rate_thresh = 16'($urandom);
      endcase
      rnd_rate = (p % 4 == 3);
      send_pkt($urandom_range(1, 30), 40, 0, 0);
    end
    rnd_rate = 0;
    drain();
    rdy_mode = 0;

    // Beat outside a packet passes unmodified and flags framing
    inject_en = 1; rate_thresh = 16'hFFFF; err_limit = 8'd10; xq.delete();
    send_pkt(1, 1, 0, 1); drain();
    chk("fr_unmodified", xq[0], 8'h00);
    chk("fr_flag", framing_err, st(1));
    send_pkt(1, 1, 0, 0); drain();
    chk("fr_one_beat_errs", errs_injected, st(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
